lieat_vsetvl_ctrl: RTL and testbench
====================================

Name: lieat_vsetvl_ctrl

Overview:
Sequences vsetvl/vsetvli/vsetivli execution for the VPU. It accepts a configuration request from issue and computes the new vl/vtype (VLMAX, legality, vill). It waits for in-flight vector instructions to drain, then writes the vector CSR file with a single-cycle write strobe. Finally it returns the new vl to the scalar writeback path. It is the only writer of the vl/vtype CSR registers.

Parameters:
XLEN, 32, scalar/vtype width
VLEN, 128, vector register length in bits
ELEN, 32, max supported SEW
VL_W, 5, width of the vl CSR (must hold VLEN/8)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
req_valid  in  1  config request valid
req_ready  out  1  controller can accept (IDLE only)
req_avl  in  XLEN  AVL (rs1 value or uimm, zero-extended)
req_vtype  in  XLEN  requested vtype
req_rs1_x0  in  1  rs1 field is x0 (not for vsetivli)
req_rd_x0  in  1  rd field is x0
flush  in  1  pipeline kill
vpu_busy  in  1  vector instructions in flight that use vl/vtype
csr_vl_rdata  in  VL_W  current vl
csr_vl_wen  out  1  vl write strobe
csr_vl_wdata  out  VL_W  new vl
csr_vtype_wen  out  1  vtype write strobe
csr_vtype_wdata  out  XLEN  new vtype
resp_valid  out  1  rd result valid
resp_ready  in  1  writeback accepts
resp_vl  out  XLEN  new vl, zero-extended
busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; all wen=0; resp_valid=0; wdata/resp_vl=0; latched request cleared. Reset mid-operation abandons the request with no CSR write.
- vtype fields: vlmul[2:0], vsew[5:3], vta[6], vma[7], vill[XLEN-1].
- A vtype is illegal, forcing vill, if any of these hold:
  - bits [XLEN-2:8] are nonzero;
  - vsew > 010 (SEW > 32);
  - vlmul is 100, 001, 010 or 011 (LMUL > 1 is not supported);
  - SEW > LMUL*ELEN. This makes LMUL=1/8 illegal for all SEW, and LMUL=1/4 legal only with SEW8.
- VLMAX = (VLEN >> (3+vsew)) >> f, where f=0/1/2/3 for vlmul 000/111/110/101.
- New vl, legal case:
  - rs1!=x0: vl = min(AVL, VLMAX), with the compare done at full XLEN.
  - rs1==x0 and rd!=x0: vl = VLMAX.
  - both x0: vl = csr_vl_rdata. If csr_vl_rdata > VLMAX, the result is treated as illegal.
- Illegal case: vtype_wdata = 1<<(XLEN-1), vl=0.
- FSM states and transitions:
  - IDLE: req_ready=1. When req_valid&&!flush, latch the request and go to DRAIN. A request in the same cycle as flush is dropped.
  - DRAIN: stays while vpu_busy. When !vpu_busy, go to COMMIT. flush here returns to IDLE with no write.
  - COMMIT (exactly 1 cycle): csr_vl_wen=csr_vtype_wen=1 with computed data, then go to RESP. flush is ignored; COMMIT is the commit point.
  - RESP: resp_valid=1 and resp_vl is held stable until resp_ready, then IDLE. flush is ignored. req_ready=0.
- Minimum latency: accept at edge 0; COMMIT strobe during cycle 2; resp_valid during cycle 3 (with vpu_busy=0 and resp_ready=1). Back-to-back throughput: one request per 4 cycles.
- Wen is asserted only in COMMIT and never more than one cycle per request.

Decomposition:
- Shared package: vtype field bit positions, VILL_BIT, and the FSM state encoding (IDLE/DRAIN/COMMIT/RESP, 2-bit).
- Sub-module lieat_vlmax_calc (combinational): vtype in; vlmax[VL_W:0] and illegal out. It is instantiated once on the latched vtype.

Test Plan:
- vtype=0x00000008 (SEW16, LMUL1), AVL=20, rs1!=x0 -> COMMIT writes vl=8, vtype=0x8; resp_vl=8 in cycle 3.
- vtype=0x00000007 (SEW8, LMUL1/2), rs1=x0, rd!=x0 -> vl=8. Then vtype=0x0, AVL=0xFFFFFFFF -> vl=16. Then AVL=0 -> vl=0.
- vtype=0x00000018 (SEW64), then vtype=0x00000005 with SEW8 (LMUL1/8), then vtype=0x100 (reserved bit) -> each gives vtype_wdata=0x80000000, vl=0.
- csr_vl=16; both x0 with vtype=0x8 -> vill, vl=0. Both x0 with vtype=0x0 -> vl stays 16.
- vpu_busy held 5 cycles after accept -> wen only after busy drops. flush during DRAIN -> no wen, no resp, req_ready=1 next cycle.
- resp_ready low 3 cycles -> resp_valid/resp_vl stable, req_ready=0. reset=0 in DRAIN -> IDLE, no wen, resp_valid=0.

Source files
------------

// File: rtl/lieat_vsetvl_ctrl_pkg.sv
// Shared definitions for the vsetvl controller: vtype field layout and FSM encoding.
package lieat_vsetvl_ctrl_pkg;

    localparam int VLMUL_LSB = 0;
    localparam int VLMUL_MSB = 2;
    localparam int VSEW_LSB  = 3;
    localparam int VSEW_MSB  = 5;
    localparam int VTA_BIT   = 6;
    localparam int VMA_BIT   = 7;
    localparam int RSVD_LSB  = 8;
    localparam int VILL_BIT  = 31;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

endpackage

// File: rtl/lieat_vlmax_calc.sv
// Combinational VLMAX and legality evaluation of a requested vtype.
module lieat_vlmax_calc
    import lieat_vsetvl_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 128,
    parameter int ELEN = 32,
    parameter int VL_W = 5
) (
    input  logic [XLEN-1:0] vtype,
    output logic [VL_W:0]   vlmax,
    output logic            illegal
);

    localparam int VLMAX_W = VL_W + 1;

    logic [2:0] vsew;
    logic [2:0] vlmul;
    logic [1:0] frac;
    logic       lmul_ok;
    logic       rsvd_set;
    logic       sew_ok;
    logic       sew_fits;
    logic       unused_bits;

    assign vsew        = vtype[VSEW_MSB:VSEW_LSB];
    assign vlmul       = vtype[VLMUL_MSB:VLMUL_LSB];
    assign rsvd_set    = |vtype[XLEN-2:RSVD_LSB];
    assign unused_bits = ^{vtype[VMA_BIT:VTA_BIT], vtype[XLEN-1]};

    // Only LMUL <= 1 is supported; frac is log2 of the LMUL divisor.
    always_comb begin
        frac    = 2'd0;
        lmul_ok = 1'b1;
        case (vlmul)
            3'b000:  frac = 2'd0;
            3'b111:  frac = 2'd1;
            3'b110:  frac = 2'd2;
            3'b101:  frac = 2'd3;
            default: lmul_ok = 1'b0;
        endcase
    end

    assign sew_ok   = (vsew <= 3'd2);
    assign sew_fits = ((32'd8 << vsew) <= (32'(ELEN) >> frac));
    assign illegal  = rsvd_set || !sew_ok || !lmul_ok || !sew_fits;
    assign vlmax    = VLMAX_W'((32'(VLEN) >> 3) >> vsew >> frac);

endmodule

// File: rtl/lieat_vsetvl_ctrl.sv
// vsetvl sequencer: latch request, drain the VPU, commit vl/vtype once, return vl to writeback.
module lieat_vsetvl_ctrl
    import lieat_vsetvl_ctrl_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int VLEN = 128,
    parameter int ELEN = 32,
    parameter int VL_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_avl,
    input  logic [XLEN-1:0] req_vtype,
    input  logic            req_rs1_x0,
    input  logic            req_rd_x0,
    input  logic            flush,
    input  logic            vpu_busy,
    input  logic [VL_W-1:0] csr_vl_rdata,
    output logic            csr_vl_wen,
    output logic [VL_W-1:0] csr_vl_wdata,
    output logic            csr_vtype_wen,
    output logic [XLEN-1:0] csr_vtype_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_vl,
    output logic            busy
);

    state_e          state;
    state_e          state_nxt;
    logic [XLEN-1:0] avl_q;
    logic [XLEN-1:0] vtype_q;
    logic            rs1_x0_q;
    logic            rd_x0_q;
    logic [VL_W-1:0] vl_q;
    logic [VL_W:0]   vlmax;
    logic            vtype_illegal;
    logic            csr_vl_over;
    logic            cfg_illegal;
    logic [VL_W-1:0] vl_legal;
    logic [VL_W-1:0] vl_new;
    logic [XLEN-1:0] vtype_new;
    logic            commit;
    logic            accept;

    lieat_vlmax_calc #(
        .XLEN (XLEN),
        .VLEN (VLEN),
        .ELEN (ELEN),
        .VL_W (VL_W)
    ) u_vlmax_calc (
        .vtype   (vtype_q),
        .vlmax   (vlmax),
        .illegal (vtype_illegal)
    );

    // Keeping the current vl is only legal if it still fits the new VLMAX.
    assign csr_vl_over = ({1'b0, csr_vl_rdata} > vlmax);

    always_comb begin
        cfg_illegal = vtype_illegal || (rs1_x0_q && rd_x0_q && csr_vl_over);
        vl_legal    = csr_vl_rdata;
        if (!rs1_x0_q) begin
            vl_legal = (avl_q < XLEN'(vlmax)) ? VL_W'(avl_q) : VL_W'(vlmax);
        end else if (!rd_x0_q) begin
            vl_legal = VL_W'(vlmax);
        end
        vl_new    = cfg_illegal ? '0 : vl_legal;
        vtype_new = cfg_illegal ? {1'b1, {(XLEN-1){1'b0}}} : vtype_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        busy       = 1'b1;
        commit     = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid && !flush) begin
                    accept    = 1'b1;
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (flush) begin
                    state_nxt = ST_IDLE;
                end else if (!vpu_busy) begin
                    state_nxt = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            avl_q    <= '0;
            vtype_q  <= '0;
            rs1_x0_q <= 1'b0;
            rd_x0_q  <= 1'b0;
            vl_q     <= '0;
        end else begin
            if (accept) begin
                avl_q    <= req_avl;
                vtype_q  <= req_vtype;
                rs1_x0_q <= req_rs1_x0;
                rd_x0_q  <= req_rd_x0;
            end
            if (commit) begin
                vl_q <= vl_new;
            end
        end
    end

    assign csr_vl_wen      = commit;
    assign csr_vtype_wen   = commit;
    assign csr_vl_wdata    = commit ? vl_new : '0;
    assign csr_vtype_wdata = commit ? vtype_new : '0;
    assign resp_vl         = XLEN'(vl_q);

endmodule

// File: tb/tb_lieat_vsetvl_ctrl.sv
// Scoreboard bench for lieat_vsetvl_ctrl: directed vsetvl requests with hand-computed results.
module tb_lieat_vsetvl_ctrl;

    localparam int XLEN = 32;
    localparam int VL_W = 5;
    localparam logic [31:0] ILL = 32'h8000_0000;

    logic            clock = 1'b0;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_avl;
    logic [XLEN-1:0] req_vtype;
    logic            req_rs1_x0;
    logic            req_rd_x0;
    logic            flush;
    logic            vpu_busy;
    logic [VL_W-1:0] csr_vl_rdata;
    logic            csr_vl_wen;
    logic [VL_W-1:0] csr_vl_wdata;
    logic            csr_vtype_wen;
    logic [XLEN-1:0] csr_vtype_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_vl;
    logic            busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [VL_W-1:0] vl;
        logic [XLEN-1:0] vt;
    } commit_t;

    commit_t         exp_commit[$];
    logic [XLEN-1:0] exp_resp[$];

    always #5 clock = ~clock;

    lieat_vsetvl_ctrl dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_avl         (req_avl),
        .req_vtype       (req_vtype),
        .req_rs1_x0      (req_rs1_x0),
        .req_rd_x0       (req_rd_x0),
        .flush           (flush),
        .vpu_busy        (vpu_busy),
        .csr_vl_rdata    (csr_vl_rdata),
        .csr_vl_wen      (csr_vl_wen),
        .csr_vl_wdata    (csr_vl_wdata),
        .csr_vtype_wen   (csr_vtype_wen),
        .csr_vtype_wdata (csr_vtype_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_vl         (resp_vl),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every CSR write and every accepted response is matched against the scoreboard.
    initial begin
        commit_t         ce;
        logic [XLEN-1:0] re;
        forever begin
            @(negedge clock);
            #1;
            if (csr_vl_wen === 1'b1 || csr_vtype_wen === 1'b1) begin
                if (exp_commit.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: vl_wen=%0b vtype_wen=%0b required no write",
                             csr_vl_wen, csr_vtype_wen);
                end else begin
                    ce = exp_commit.pop_front();
                    chk("commit_vl_wen", 32'(csr_vl_wen), 32'd1);
                    chk("commit_vtype_wen", 32'(csr_vtype_wen), 32'd1);
                    chk("commit_vl", 32'(csr_vl_wdata), 32'(ce.vl));
                    chk("commit_vtype", csr_vtype_wdata, ce.vt);
                end
            end
            if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
                if (exp_resp.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: resp_vl=0x%0h required no response", resp_vl);
                end else begin
                    re = exp_resp.pop_front();
                    chk("resp_vl", resp_vl, re);
                end
            end
        end
    end

    // Issue one request at a negedge in IDLE; returns at a negedge back in IDLE.
    task automatic run_req(input logic [31:0] avl, input logic [31:0] vt,
                           input logic rs1x0, input logic rdx0,
                           input logic [VL_W-1:0] exp_vl, input logic [31:0] exp_vt,
                           input int busy_cyc, input int stall);
        commit_t ce;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        ce.vl = exp_vl;
        ce.vt = exp_vt;
        exp_commit.push_back(ce);
        exp_resp.push_back(32'(exp_vl));
        req_avl    = avl;
        req_vtype  = vt;
        req_rs1_x0 = rs1x0;
        req_rd_x0  = rdx0;
        req_valid  = 1'b1;
        vpu_busy   = (busy_cyc > 0);
        resp_ready = (stall == 0);
        @(negedge clock);
        req_valid = 1'b0;
        chk("drain_busy", 32'(busy), 32'd1);
        chk("drain_no_wen", 32'(csr_vl_wen), 32'd0);
        for (int i = 0; i < busy_cyc; i++) begin
            @(negedge clock);
            chk("busy_hold_no_wen", 32'(csr_vl_wen), 32'd0);
        end
        vpu_busy = 1'b0;
        @(negedge clock);
        chk("commit_strobe", 32'(csr_vl_wen), 32'd1);
        chk("commit_no_resp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("wen_single_cycle", 32'(csr_vl_wen), 32'd0);
        chk("resp_req_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_vl", resp_vl, 32'(exp_vl));
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clock);
        chk("back_idle", 32'(req_ready), 32'd1);
        chk("resp_dropped", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        req_valid    = 1'b0;
        req_avl      = '0;
        req_vtype    = '0;
        req_rs1_x0   = 1'b0;
        req_rd_x0    = 1'b0;
        flush        = 1'b0;
        vpu_busy     = 1'b0;
        csr_vl_rdata = 5'd16;
        resp_ready   = 1'b1;

        repeat (2) @(negedge clock);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vl_wen", 32'(csr_vl_wen), 32'd0);
        chk("rst_vtype_wen", 32'(csr_vtype_wen), 32'd0);
        chk("rst_vl_wdata", 32'(csr_vl_wdata), 32'd0);
        chk("rst_vtype_wdata", csr_vtype_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_vl", resp_vl, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Legal configurations, minimum latency, back-to-back.
        run_req(32'd20, 32'h08, 1'b0, 1'b0, 5'd8, 32'h08, 0, 0);
        run_req(32'h55, 32'h07, 1'b1, 1'b0, 5'd8, 32'h07, 0, 0);
        run_req(32'hFFFF_FFFF, 32'h00, 1'b0, 1'b0, 5'd16, 32'h00, 0, 0);
        run_req(32'd0, 32'h00, 1'b0, 1'b0, 5'd0, 32'h00, 0, 0);
        run_req(32'd3, 32'h06, 1'b0, 1'b0, 5'd3, 32'h06, 0, 0);
        run_req(32'd5, 32'hC8, 1'b0, 1'b0, 5'd5, 32'hC8, 0, 0);

        // Illegal vtypes.
        run_req(32'd4, 32'h18, 1'b0, 1'b0, 5'd0, ILL, 0, 0);
        run_req(32'd4, 32'h05, 1'b0, 1'b0, 5'd0, ILL, 0, 0);
        run_req(32'd4, 32'h100, 1'b0, 1'b0, 5'd0, ILL, 0, 0);
        run_req(32'd4, 32'h0E, 1'b0, 1'b0, 5'd0, ILL, 0, 0);
        run_req(32'd4, 32'h01, 1'b0, 1'b0, 5'd0, ILL, 0, 0);

        // Keep-vl form, rs1 and rd both x0.
        run_req(32'h55, 32'h08, 1'b1, 1'b1, 5'd0, ILL, 0, 0);
        run_req(32'h55, 32'h00, 1'b1, 1'b1, 5'd16, 32'h00, 0, 0);
        csr_vl_rdata = 5'd3;
        run_req(32'h55, 32'h08, 1'b1, 1'b1, 5'd3, 32'h08, 0, 0);
        csr_vl_rdata = 5'd16;

        // Drain stall and writeback backpressure.
        run_req(32'd20, 32'h08, 1'b0, 1'b0, 5'd8, 32'h08, 5, 0);
        run_req(32'hFFFF_FFFF, 32'h00, 1'b0, 1'b0, 5'd16, 32'h00, 0, 3);

        // Request coinciding with flush in IDLE is dropped.
        req_valid = 1'b1;
        req_vtype = 32'h00;
        req_avl   = 32'd9;
        flush     = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        flush     = 1'b0;
        chk("flush_idle_busy", 32'(busy), 32'd0);
        chk("flush_idle_ready", 32'(req_ready), 32'd1);

        // Flush during DRAIN abandons the request.
        req_valid = 1'b1;
        vpu_busy  = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("flush_drain_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clock);
        flush    = 1'b0;
        vpu_busy = 1'b0;
        chk("flush_drain_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("flush_no_wen", 32'(csr_vl_wen), 32'd0);
            chk("flush_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clock);
        end

        // Reset during DRAIN abandons the request and clears the held vl.
        req_valid = 1'b1;
        vpu_busy  = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clock);
        reset    = 1'b1;
        vpu_busy = 1'b0;
        chk("rst_drain_busy", 32'(busy), 32'd0);
        chk("rst_drain_resp_vl", resp_vl, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_drain_no_wen", 32'(csr_vl_wen), 32'd0);
            chk("rst_drain_no_resp", 32'(resp_valid), 32'd0);
            @(negedge clock);
        end

        run_req(32'd7, 32'h08, 1'b0, 1'b0, 5'd7, 32'h08, 0, 0);

        repeat (2) @(negedge clock);
        chk("sb_commit_empty", 32'(exp_commit.size()), 32'd0);
        chk("sb_resp_empty", 32'(exp_resp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
